mux_scan_sel: RTL and testbench

Parametrised, registered 2^SEL_W-to-1 channel multiplexer with two modes. In direct mode the output follows an externally driven select. In scan mode an internal dwell timer steps automatically through the channels enabled in a mask. It replaces the fixed combinational 1-of-4 and 1-of-16 selectors in the datapath. Use it wherever a channel must be picked by software or cycled through for time-division readout, such as display multiplexing or sensor polling.

---
 rtl/mux_scan_sel.sv | 98 +++++++++
 tb/tb_mux_scan_sel.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sel.sv
// Registered 2^SEL_W-to-1 channel multiplexer.
// Direct mode follows sel; scan mode dwells on each channel enabled in mask, then moves on.
module mux_scan_sel #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned SEL_W = 4,
    parameter int unsigned DWELL = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic                           mode,
    input  logic [SEL_W-1:0]               sel,
    input  logic [(2**SEL_W)-1:0]          mask,
    input  logic [WIDTH*(2**SEL_W)-1:0]    data_in,
    output logic [WIDTH-1:0]               out,
    output logic [SEL_W-1:0]               ch,
    output logic                           valid,
    output logic                           wrap
);

    localparam int unsigned CH   = 2 ** SEL_W;
    localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

    logic [WIDTH-1:0] chans [CH];
    logic [DW_W-1:0]  dwell;
    logic [DW_W-1:0]  dwell_d;
    logic [SEL_W-1:0] ch_d;
    logic [WIDTH-1:0] out_d;
    logic             valid_d;
    logic             wrap_d;
    logic [SEL_W-1:0] scan_ch;
    logic [SEL_W-1:0] cand;
    logic             found;
    logic             adv;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        assign chans[i] = data_in[i*WIDTH +: WIDTH];
    end

    // Circular priority search starting at ch+1; k = CH lands back on ch itself.
    always_comb begin
        scan_ch = ch;
        cand    = '0;
        found   = 1'b0;
        for (int unsigned k = 1; k <= CH; k++) begin
            cand = ch + SEL_W'(k);
            if (!found && mask[cand]) begin
                found   = 1'b1;
                scan_ch = cand;
            end
        end
    end

    // Next-state selection; an all-zero mask in scan mode holds everything but drops valid.
    always_comb begin
        ch_d    = ch;
        out_d   = out;
        dwell_d = dwell;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        adv     = 1'b0;
        if (!mode) begin
            ch_d    = sel;
            out_d   = chans[sel];
            dwell_d = '0;
            valid_d = 1'b1;
        end else if (|mask) begin
            adv     = (dwell == DWELL_LAST) || !mask[ch];
            valid_d = 1'b1;
            if (adv) begin
                ch_d    = scan_ch;
                dwell_d = '0;
                wrap_d  = (scan_ch <= ch);
            end else begin
                dwell_d = dwell + DW_W'(1);
            end
            out_d = chans[ch_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out   <= '0;
            ch    <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
            dwell <= '0;
        end else if (en) begin
            out   <= out_d;
            ch    <= ch_d;
            valid <= valid_d;
            wrap  <= wrap_d;
            dwell <= dwell_d;
        end
    end

endmodule

// File: tb/tb_mux_scan_sel.sv
// Scoreboard bench for mux_scan_sel: a DWELL=4 instance and a DWELL=1 instance on shared inputs.
// The driver queues hand-derived expectations; the monitor pops and compares after each edge.
module tb_mux_scan_sel;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        mode;
    logic [3:0]  sel;
    logic [15:0] mask;
    logic [63:0] data_in;

    logic [3:0]  out0, ch0, out1, ch1;
    logic        valid0, wrap0, valid1, wrap1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [3:0] o0;
        logic [3:0] c0;
        logic       v0;
        logic       w0;
        bit         chk1;
        logic [3:0] o1;
        logic [3:0] c1;
        logic       v1;
        logic       w1;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   vec_id = 0;

    mux_scan_sel #(.WIDTH(4), .SEL_W(4), .DWELL(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .mask(mask),
        .data_in(data_in), .out(out0), .ch(ch0), .valid(valid0), .wrap(wrap0)
    );

    mux_scan_sel #(.WIDTH(4), .SEL_W(4), .DWELL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .mask(mask),
        .data_in(data_in), .out(out1), .ch(ch1), .valid(valid1), .wrap(wrap1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: evaluate shortly after every edge or asynchronous reset assertion.
    always begin
        @(posedge clk or negedge rst_n);
        #1;
        if (q.size() > 0) begin
            me = q.pop_front();
            vectors++;
            if ({out0, ch0, valid0, wrap0} !== {me.o0, me.c0, me.v0, me.w0}) begin
                miscompares++;
                $display("FAIL vec%0d dut0 out/ch/valid/wrap got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d",
                         vec_id, out0, ch0, valid0, wrap0, me.o0, me.c0, me.v0, me.w0);
            end
            if (me.chk1) begin
                vectors++;
                if ({out1, ch1, valid1, wrap1} !== {me.o1, me.c1, me.v1, me.w1}) begin
                    miscompares++;
                    $display("FAIL vec%0d dut1 out/ch/valid/wrap got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d",
                             vec_id, out1, ch1, valid1, wrap1, me.o1, me.c1, me.v1, me.w1);
                end
            end
            vec_id++;
        end
    end

    task automatic push2(input logic [3:0] o, input logic [3:0] c, input logic v, input logic w,
                         input logic [3:0] o1, input logic [3:0] c1, input logic v1, input logic w1);
        exp_t e;
        e = '{o, c, v, w, 1'b1, o1, c1, v1, w1};
        q.push_back(e);
    endtask

    // Queue one expectation for the coming edge, then advance to the next falling edge.
    task automatic step(input logic [3:0] o, input logic [3:0] c, input logic v, input logic w);
        exp_t e;
        e = '{o, c, v, w, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic step2(input logic [3:0] o, input logic [3:0] c, input logic v, input logic w,
                         input logic [3:0] o1, input logic [3:0] c1, input logic v1, input logic w1);
        push2(o, c, v, w, o1, c1, v1, w1);
        @(negedge clk);
    endtask

    // Channel i carries i, or 15-i when reversed.
    task automatic set_data(input bit rev);
        for (int i = 0; i < 16; i++)
            data_in[i*4 +: 4] = rev ? 4'(15 - i) : 4'(i);
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b1;
        mode    = 1'($urandom);
        sel     = 4'($urandom);
        mask    = 16'($urandom);
        data_in = {$urandom, $urandom};
        @(negedge clk);

        step2(0, 0, 0, 0, 0, 0, 0, 0);
        mode = 1'($urandom); sel = 4'($urandom); data_in = {$urandom, $urandom};
        step2(0, 0, 0, 0, 0, 0, 0, 0);

        rst_n = 1'b1; mode = 1'b0; sel = 4'd5; mask = 16'hFFFF; set_data(0);
        step2(5, 5, 1, 0, 5, 5, 1, 0);

        sel = 4'd0;  step(0, 0, 1, 0);
        sel = 4'd15; step(15, 15, 1, 0);
        sel = 4'd7;  step(7, 7, 1, 0);
        set_data(1); step(8, 7, 1, 0);
        set_data(0); sel = 4'd0; step(0, 0, 1, 0);

        // Full sweep: ch 0 already shown once in direct mode.
        mode = 1'b1; mask = 16'hFFFF;
        for (int e = 0; e < 3; e++) step(0, 0, 1, 0);
        for (int c = 1; c < 16; c++)
            for (int d = 0; d < 4; d++) step(4'(c), 4'(c), 1, 0);
        step(0, 0, 1, 1);

        mode = 1'b0; sel = 4'd0; step(0, 0, 1, 0);

        // Sparse mask 0 <-> 4.
        mode = 1'b1; mask = 16'h0011;
        for (int e = 0; e < 3; e++) step(0, 0, 1, 0);
        for (int e = 0; e < 4; e++) step(4, 4, 1, 0);
        step(0, 0, 1, 1);
        for (int e = 0; e < 3; e++) step(0, 0, 1, 0);
        step(4, 4, 1, 0);

        mask = 16'h0000; set_data(1);
        step(4, 4, 0, 0);
        step(4, 4, 0, 0);
        set_data(0);

        // Current channel masked out: jump immediately; single-bit mask wraps onto itself.
        mode = 1'b0; sel = 4'd3; step2(3, 3, 1, 0, 3, 3, 1, 0);
        mode = 1'b1; mask = 16'h0100;
        step2(8, 8, 1, 0, 8, 8, 1, 0);
        for (int e = 0; e < 3; e++) step2(8, 8, 1, 0, 8, 8, 1, 1);
        step2(8, 8, 1, 1, 8, 8, 1, 1);

        // Enable low: everything frozen, including the wrap pulse, despite new data.
        en = 1'b0; set_data(1);
        for (int e = 0; e < 5; e++) step2(8, 8, 1, 1, 8, 8, 1, 1);
        en = 1'b1;
        for (int e = 0; e < 3; e++) step2(7, 8, 1, 0, 7, 8, 1, 1);
        step2(7, 8, 1, 1, 7, 8, 1, 1);
        step2(7, 8, 1, 0, 7, 8, 1, 1);

        // Asynchronous reset between edges, mid-dwell.
        push2(0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        step2(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1; mode = 1'b0; sel = 4'd5; set_data(0);
        step2(5, 5, 1, 0, 5, 5, 1, 0);

        @(negedge clk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain pending %0d exp 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
